iob_skid_buf: RTL and testbench
===============================

Name: iob_skid_buf

Overview:
- Two-entry elastic register: the consumer-driven reading end of an enabled pipeline register.
- The upstream producer writes words with a valid/ready handshake. The downstream consumer drains them with its own valid/ready handshake.
- in_ready_o is registered, which breaks the combinational ready path between pipeline stages. Full throughput is sustained at one word per cycle.
- Used between iob_cache datapath stages wherever a stage must stall without a combinational back-pressure path.

Parameters:
- DATA_W, 32, width of the data word.
- RST_VAL, {DATA_W{1'b0}}, value of out_data_o and both internal data registers after reset.

Ports:
- clk_i  input  1  clock, rising edge.
- cke_i  input  1  clock enable; 0 freezes all state.
- arst_n_i  input  1  asynchronous reset, active-low.
- in_valid_i  input  1  producer word valid.
- in_data_i  input  DATA_W  producer word.
- in_ready_o  output  1  buffer can accept a word.
- out_valid_o  output  1  consumer word valid.
- out_data_o  output  DATA_W  consumer word (head of buffer).
- out_ready_i  input  1  consumer accepts the word.
- level_o  output  2  occupancy, 0..2; present only with IOB_SKID_BUF_LEVEL_EN.

Behaviour:
- Storage:
  - main register: head word, drives out_data_o, flag main_v.
  - skid register: second word, flag skid_v.
- States, encoded by {skid_v, main_v}:
  - EMPTY = 00
  - ONE = 01
  - FULL = 11
  - 10 is unreachable.
- Handshake rules:
  - in_acc = in_valid_i & in_ready_o.
  - out_acc = out_valid_o & out_ready_i.
  - A transfer happens only on a rising clk_i edge with cke_i=1.
- Output logic:
  - out_valid_o = main_v & cke_i & arst_n_i.
  - in_ready_o = ~skid_v & cke_i & arst_n_i. It depends only on registered state; there is no path from out_ready_i or in_valid_i.
- Transitions (evaluated when cke_i=1):
  - EMPTY, in_acc -> ONE, main<=in_data_i.
  - EMPTY, no in_acc -> EMPTY.
  - ONE, in_acc & out_acc -> ONE, main<=in_data_i (pass-through, full throughput).
  - ONE, in_acc only -> FULL, skid<=in_data_i, main unchanged.
  - ONE, out_acc only -> EMPTY.
  - ONE, neither -> ONE, hold.
  - FULL, out_acc -> ONE, main<=skid. in_ready_o is 0 in FULL, so no simultaneous input.
  - FULL, no out_acc -> FULL, hold.
- Ordering: words leave in exactly the order accepted. No word is dropped or duplicated.
- Latency: a word accepted in EMPTY appears on out_data_o/out_valid_o the next cycle.
- Data registers load only on the transitions above. Otherwise they hold; stale contents are not cleared.
- cke_i=0:
  - all registers hold;
  - in_ready_o=0 and out_valid_o=0, so no handshake completes;
  - out_data_o holds.
- Reset (arst_n_i low, asynchronous, immediate):
  - main_v=0, skid_v=0;
  - main and skid data = RST_VAL;
  - out_valid_o=0, in_ready_o=0, out_data_o=RST_VAL.
- Reset mid-operation: stored words are discarded. After release the buffer is EMPTY, and in_ready_o=1 from the first cycle (when cke_i=1).
- in_data_i is don't-care when in_valid_i=0. out_data_o is don't-care when out_valid_o=0.

Optional Feature:
- Macro IOB_SKID_BUF_LEVEL_EN.
- Defined:
  - port level_o exists, = main_v + skid_v (0 EMPTY, 1 ONE, 2 FULL), registered-state derived;
  - reset value 0;
  - not gated by cke_i.
- Undefined: level_o port is absent. All other behaviour is identical.

Test Plan (DATA_W=8, RST_VAL=8'h00):
- Reset: hold arst_n_i=0 with in_valid_i=1, in_data_i=8'hAA -> out_valid_o=0, in_ready_o=0, out_data_o=8'h00. After release the first in_acc of 8'h11 gives out_valid_o=1, out_data_o=8'h11 next cycle.
- Streaming: out_ready_i=1, in_valid_i=1 with data 8'h01..8'h10 on consecutive cycles -> out sequence 01..10, one per cycle, 1-cycle latency, in_ready_o never drops.
- Back-pressure: out_ready_i=0, push 8'hA1, 8'hA2 -> in_ready_o=0 after the second accept, level_o=2 (macro on). 8'hA3 held on input is not accepted. Then raise out_ready_i -> outputs A1, A2, A3 in order.
- Simultaneous in/out in ONE: main=8'h55, present 8'h66 with out_ready_i=1 -> 55 leaves, main=66, state stays ONE, level_o=1.
- cke_i=0 while FULL (C1, C2 stored), out_ready_i=1 for 3 cycles -> out_valid_o=0, no word lost. Re-enable -> C1 then C2.
- Reset asserted mid-stream in FULL -> immediate out_valid_o=0, out_data_o=8'h00. After release level_o=0 and in_ready_o=1.

Source files
------------

// File: rtl/iob_skid_buf.sv
// Purpose : two-entry elastic register with a registered in_ready_o, used to break the ready path between stages.
// Latency : 1 cycle from an accepted input word to out_valid_o/out_data_o; one word per cycle sustained.
// Backpr. : in_ready_o drops only when the skid register is occupied; it never depends on out_ready_i.
//
// Ports:
//   clk_i, cke_i, arst_n_i         clock (rising edge), clock enable (0 freezes state), async active-low reset
//   in_valid_i/in_data_i/in_ready_o    producer handshake
//   out_valid_o/out_data_o/out_ready_i consumer handshake; out_data_o is the head (main) register
//   level_o                        occupancy 0..2, present only when IOB_SKID_BUF_LEVEL_EN is defined
module iob_skid_buf #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
`ifdef IOB_SKID_BUF_LEVEL_EN
  ,
  output logic [1:0]        level_o
`endif
);

  // State encoding is {skid_v, main_v}; 2'b10 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic main_v;
  logic skid_v;
  logic in_acc;
  logic out_acc;

  assign main_v = state_q[0];
  assign skid_v = state_q[1];

  // Gating with cke_i and arst_n_i guarantees no handshake can complete
  // while state is frozen or being reset.
  assign in_ready_o  = ~skid_v & cke_i & arst_n_i;
  assign out_valid_o = main_v  & cke_i & arst_n_i;
  assign out_data_o  = main_q;

  assign in_acc  = in_valid_i  & in_ready_o;
  assign out_acc = out_valid_o & out_ready_i;

`ifdef IOB_SKID_BUF_LEVEL_EN
  assign level_o = {1'b0, main_v} + {1'b0, skid_v};
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_acc) begin
          state_d = ONE;
          main_d  = in_data_i;
        end
      end
      ONE: begin
        if (in_acc && out_acc) begin
          // Pass-through: head leaves while the new word takes its place.
          main_d = in_data_i;
        end else if (in_acc) begin
          state_d = FULL;
          skid_d  = in_data_i;
        end else if (out_acc) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready_o is low here, so only the drain side can move.
        if (out_acc) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else if (cke_i) begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_iob_skid_buf.sv
module tb_iob_skid_buf;

  logic       clk_i = 1'b0;
  logic       cke_i;
  logic       arst_n_i;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_ready_o;
  logic       out_valid_o;
  logic [7:0] out_data_o;
  logic       out_ready_i;
`ifdef IOB_SKID_BUF_LEVEL_EN
  logic [1:0] level_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  iob_skid_buf #(
    .DATA_W  (8),
    .RST_VAL (8'h00)
  ) dut (
    .clk_i       (clk_i),
    .cke_i       (cke_i),
    .arst_n_i    (arst_n_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i)
`ifdef IOB_SKID_BUF_LEVEL_EN
    ,
    .level_o     (level_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lvl(input string tag, input logic [1:0] exp);
`ifdef IOB_SKID_BUF_LEVEL_EN
    chk(tag, {30'd0, level_o}, {30'd0, exp});
`endif
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    cke_i       = 1'b1;
    arst_n_i    = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 8'hAA;
    out_ready_i = 1'b0;

    // Reset held with a valid word on the input
    #3;
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready_o},  32'd0);
    chk("rst_out_data",  {24'd0, out_data_o},  32'h00);
    chk_lvl("rst_level", 2'd0);
    tick();
    tick();
    chk("rst_hold_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_hold_data",  {24'd0, out_data_o},  32'h00);

    arst_n_i  = 1'b1;
    in_data_i = 8'h11;
    #1;
    chk("rel_in_ready",  {31'd0, in_ready_o},  32'd1);
    chk("rel_out_valid", {31'd0, out_valid_o}, 32'd0);
    tick();
    chk("first_valid", {31'd0, out_valid_o}, 32'd1);
    chk("first_data",  {24'd0, out_data_o},  32'h11);
    chk_lvl("first_level", 2'd1);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    chk("drain_valid", {31'd0, out_valid_o}, 32'd0);

    // Streaming 01..10 with the consumer always ready
    for (int i = 1; i <= 16; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'(i);
      #1;
      chk("stream_in_ready", {31'd0, in_ready_o}, 32'd1);
      tick();
      chk("stream_valid", {31'd0, out_valid_o}, 32'd1);
      chk("stream_data",  {24'd0, out_data_o},  i);
    end
    in_valid_i = 1'b0;
    tick();
    chk("stream_end_valid", {31'd0, out_valid_o}, 32'd0);
    chk_lvl("stream_end_level", 2'd0);

    // Back-pressure: fill to FULL, hold a third word, then drain in order
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 8'hA1;
    tick();
    chk("bp_one_ready", {31'd0, in_ready_o}, 32'd1);
    chk("bp_one_data",  {24'd0, out_data_o}, 32'hA1);
    in_data_i = 8'hA2;
    tick();
    chk("bp_full_ready", {31'd0, in_ready_o}, 32'd0);
    chk("bp_full_data",  {24'd0, out_data_o}, 32'hA1);
    chk_lvl("bp_full_level", 2'd2);
    in_data_i = 8'hA3;
    tick();
    chk("bp_hold_ready", {31'd0, in_ready_o}, 32'd0);
    chk("bp_hold_data",  {24'd0, out_data_o}, 32'hA1);
    chk_lvl("bp_hold_level", 2'd2);
    out_ready_i = 1'b1;
    #1;
    chk("bp_a1_valid", {31'd0, out_valid_o}, 32'd1);
    tick();
    chk("bp_a2_data",  {24'd0, out_data_o}, 32'hA2);
    chk("bp_a2_ready", {31'd0, in_ready_o}, 32'd1);
    chk_lvl("bp_a2_level", 2'd1);
    tick();
    chk("bp_a3_data",  {24'd0, out_data_o},  32'hA3);
    chk("bp_a3_valid", {31'd0, out_valid_o}, 32'd1);
    in_valid_i = 1'b0;
    tick();
    chk("bp_end_valid", {31'd0, out_valid_o}, 32'd0);

    // Simultaneous in/out while ONE
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 8'h55;
    tick();
    in_data_i   = 8'h66;
    out_ready_i = 1'b1;
    #1;
    chk("sim_head_data",  {24'd0, out_data_o},  32'h55);
    chk("sim_head_ready", {31'd0, in_ready_o},  32'd1);
    tick();
    chk("sim_new_data",  {24'd0, out_data_o},  32'h66);
    chk("sim_new_valid", {31'd0, out_valid_o}, 32'd1);
    chk_lvl("sim_level", 2'd1);
    in_valid_i = 1'b0;
    tick();
    chk("sim_end_valid", {31'd0, out_valid_o}, 32'd0);

    // Clock enable low while FULL
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 8'hC1;
    tick();
    in_data_i = 8'hC2;
    tick();
    cke_i       = 1'b0;
    out_ready_i = 1'b1;
    in_data_i   = 8'hC3;
    #1;
    chk("cke_in_ready",  {31'd0, in_ready_o},  32'd0);
    chk("cke_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk_lvl("cke_level", 2'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cke_frz_valid", {31'd0, out_valid_o}, 32'd0);
      chk("cke_frz_data",  {24'd0, out_data_o},  32'hC1);
    end
    cke_i      = 1'b1;
    in_valid_i = 1'b0;
    #1;
    chk("cke_c1_valid", {31'd0, out_valid_o}, 32'd1);
    chk("cke_c1_data",  {24'd0, out_data_o},  32'hC1);
    tick();
    chk("cke_c2_valid", {31'd0, out_valid_o}, 32'd1);
    chk("cke_c2_data",  {24'd0, out_data_o},  32'hC2);
    tick();
    chk("cke_end_valid", {31'd0, out_valid_o}, 32'd0);

    // Reset in the middle of FULL
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 8'hD1;
    tick();
    in_data_i = 8'hD2;
    tick();
    chk_lvl("mid_full_level", 2'd2);
    arst_n_i = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("mid_rst_data",  {24'd0, out_data_o},  32'h00);
    chk("mid_rst_ready", {31'd0, in_ready_o},  32'd0);
    chk_lvl("mid_rst_level", 2'd0);
    in_valid_i = 1'b0;
    tick();
    arst_n_i = 1'b1;
    #1;
    chk_lvl("mid_rel_level", 2'd0);
    chk("mid_rel_ready", {31'd0, in_ready_o},  32'd1);
    chk("mid_rel_valid", {31'd0, out_valid_o}, 32'd0);
    tick();
    chk("mid_rel_idle_valid", {31'd0, out_valid_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
